// File: rtl/bcd_seg_scanner_pkg.sv
// Shared display constants for the battle-display segment scanner: active-low
// gfedcba digit codes, blank/dash patterns, FSM states and a BCD sizing helper.
package pbs_disp_pkg;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
    };
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {LOAD, SHIFT, STORE} state_e;

    // Decimal digits needed to hold the largest w-bit unsigned value.
    function automatic int dec_digits(input int w);
        longint m;
        int     n;
        m = (longint'(1) << w) - 1;
        n = 1;
        while (m >= 10) begin
            m = m / 10;
            n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_seg_scanner_if.sv
// Value/display bundle of the segment scanner; master drives values and hold,
// slave (the scanner) drives segments and per-channel status.
interface bcd_seg_scanner_if #(
    parameter int NUM_CH  = 4,
    parameter int VAL_W   = 8,
    parameter int NUM_DIG = 3
);
    logic [NUM_CH*VAL_W-1:0]     val_in;
    logic                        hold;
    logic [NUM_CH*NUM_DIG*7-1:0] seg_out;
    logic [NUM_CH-1:0]           ch_valid;
    logic [NUM_CH-1:0]           ovf;

    modport master (output val_in, hold, input seg_out, ch_valid, ovf);
    modport slave  (input val_in, hold, output seg_out, ch_valid, ovf);
endinterface

// File: rtl/bcd_seg_scanner_seg7_decode.sv
// One BCD digit to active-low 7-segment code; non-decimal codes show blank.
module seg7_decode
    import pbs_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        if (bcd < 4'd10) seg = SEG_DIGIT[bcd];
    end
endmodule

// File: rtl/bcd_seg_scanner.sv
// Round-robin double-dabble converter feeding NUM_CH registered 7-segment displays.
// Optional LEAD_ZERO_BLANK_EN blanks zero digits above the most significant non-zero digit.
module bcd_seg_scanner
    import pbs_disp_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int VAL_W   = 8,
    parameter int NUM_DIG = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    bcd_seg_scanner_if.slave  bus
);
    localparam int BCD_N = (dec_digits(VAL_W) > NUM_DIG) ? dec_digits(VAL_W) : NUM_DIG;
    localparam int CNT_W = $clog2(VAL_W + 1);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_e                  state_q, state_d;
    logic [VAL_W-1:0]        bin_q, bin_d;
    logic [BCD_N*4-1:0]      bcd_q, bcd_d, adj;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [CH_W-1:0]         ch_idx_q, ch_idx_d;
    logic [NUM_CH-1:0][NUM_DIG-1:0][6:0] seg_q, seg_d;
    logic [NUM_CH-1:0]       ovf_q, ovf_d, vld_q, vld_d;

    logic [NUM_CH-1:0][VAL_W-1:0] val_arr;
    logic [NUM_DIG-1:0][6:0]      dec_seg, store_seg;
    logic                         store_ovf;
`ifdef LEAD_ZERO_BLANK_EN
    logic                         lead;
`endif

    assign val_arr = bus.val_in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= LOAD;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (!bus.hold) state_d = SHIFT;
            SHIFT:   if (bit_cnt_q == CNT_W'(1)) state_d = STORE;
            STORE:   state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // Add-3 correction applied before each shift.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < BCD_N; i++)
            if (bcd_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end

    genvar g;
    generate
        for (g = 0; g < NUM_DIG; g++) begin : g_dec
            seg7_decode u_dec (.bcd(bcd_q[g*4 +: 4]), .seg(dec_seg[g]));
        end
    endgenerate

    // Anything left above the displayed digits means the value does not fit.
    always_comb begin
        store_ovf = 1'b0;
        for (int i = NUM_DIG; i < BCD_N; i++)
            if (bcd_q[i*4 +: 4] != 4'd0) store_ovf = 1'b1;
        store_seg = dec_seg;
`ifdef LEAD_ZERO_BLANK_EN
        lead = 1'b1;
        for (int i = NUM_DIG - 1; i > 0; i--) begin
            if (bcd_q[i*4 +: 4] != 4'd0) lead = 1'b0;
            if (lead) store_seg[i] = SEG_BLANK;
        end
`endif
        if (store_ovf) store_seg = {NUM_DIG{SEG_DASH}};
    end

    always_comb begin
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        bit_cnt_d = bit_cnt_q;
        ch_idx_d  = ch_idx_q;
        seg_d     = seg_q;
        ovf_d     = ovf_q;
        vld_d     = vld_q;
        case (state_q)
            LOAD: begin
                if (!bus.hold) begin
                    bin_d     = val_arr[ch_idx_q];
                    bcd_d     = '0;
                    bit_cnt_d = CNT_W'(VAL_W);
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {adj, bin_q} << 1;
                bit_cnt_d      = bit_cnt_q - 1'b1;
            end
            STORE: begin
                seg_d[ch_idx_q] = store_seg;
                ovf_d[ch_idx_q] = store_ovf;
                vld_d[ch_idx_q] = 1'b1;
                ch_idx_d = (ch_idx_q == CH_W'(NUM_CH - 1)) ? '0 : ch_idx_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_q     <= '0;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
            ch_idx_q  <= '0;
            seg_q     <= {(NUM_CH*NUM_DIG){SEG_BLANK}};
            ovf_q     <= '0;
            vld_q     <= '0;
        end else begin
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            bit_cnt_q <= bit_cnt_d;
            ch_idx_q  <= ch_idx_d;
            seg_q     <= seg_d;
            ovf_q     <= ovf_d;
            vld_q     <= vld_d;
        end
    end

    assign bus.seg_out  = seg_q;
    assign bus.ch_valid = vld_q;
    assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Randomized bench for bcd_seg_scanner: 3-digit and 2-digit instances checked
// against a decimal reference model (honours LEAD_ZERO_BLANK_EN).
module tb_bcd_seg_scanner;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        hold = 1'b0;
    logic [31:0] val_in = '0;
    int          val [4];
    int          n_chk = 0;
    int          n_err = 0;

    logic [6:0] seg_tab [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
    };

    bcd_seg_scanner_if #(.NUM_CH(4), .VAL_W(8), .NUM_DIG(3)) bus1 ();
    bcd_seg_scanner_if #(.NUM_CH(4), .VAL_W(8), .NUM_DIG(2)) bus2 ();

    assign bus1.val_in = val_in;
    assign bus1.hold   = hold;
    assign bus2.val_in = val_in;
    assign bus2.hold   = hold;

    bcd_seg_scanner #(.NUM_CH(4), .VAL_W(8), .NUM_DIG(3)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1));
    bcd_seg_scanner #(.NUM_CH(4), .VAL_W(8), .NUM_DIG(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p *= 10;
        return p;
    endfunction

    // Expected display of value v on nd digits (digit 0 in the low 7 bits).
    function automatic logic [34:0] exp_disp(input int v, input int nd);
        logic [34:0] r;
        int p;
        r = '1;
        p = 1;
        if (v >= pow10(nd)) begin
            for (int d = 0; d < nd; d++) r[d*7 +: 7] = 7'b0111111;
            return r;
        end
        for (int d = 0; d < nd; d++) begin
            r[d*7 +: 7] = seg_tab[(v / p) % 10];
`ifdef LEAD_ZERO_BLANK_EN
            if (d > 0 && v < p) r[d*7 +: 7] = 7'b1111111;
`endif
            p *= 10;
        end
        return r;
    endfunction

    task automatic drive();
        for (int c = 0; c < 4; c++) val_in[c*8 +: 8] = 8'(val[c]);
    endtask

    task automatic chk_ch(input string tag, input int c, input int v);
        logic [34:0] e3, e2;
        e3 = exp_disp(v, 3);
        e2 = exp_disp(v, 2);
        chk($sformatf("%s_ch%0d_d3_v%0d", tag, c, v), bus1.seg_out[c*21 +: 21], e3[20:0]);
        chk($sformatf("%s_ch%0d_d2_v%0d", tag, c, v), bus2.seg_out[c*14 +: 14], e2[13:0]);
    endtask

    task automatic chk_blank(input string tag, input int c);
        chk($sformatf("%s_ch%0d_blank3", tag, c), bus1.seg_out[c*21 +: 21], {21{1'b1}});
        chk($sformatf("%s_ch%0d_blank2", tag, c), bus2.seg_out[c*14 +: 14], {14{1'b1}});
    endtask

    task automatic chk_status(input string tag, input logic [3:0] vld, input int v [4]);
        logic [3:0] o2;
        for (int c = 0; c < 4; c++) o2[c] = (v[c] >= 100);
        chk({tag, "_valid3"}, bus1.ch_valid, vld);
        chk({tag, "_valid2"}, bus2.ch_valid, vld);
        chk({tag, "_ovf3"}, bus1.ovf, '0);
        chk({tag, "_ovf2"}, bus2.ovf, o2 & vld);
    endtask

    int a [4];
    int b [4];
    int fixed_rows [4][4] = '{'{99, 99, 0, 9}, '{100, 10, 1, 255},
                              '{0, 0, 0, 0}, '{255, 255, 255, 255}};

    initial begin
        // Reset state, then first conversion latency on ch0.
        a = '{255, 100, 7, 0};
        val = a;
        drive();
        tick(3);
        chk("rst_seg3", bus1.seg_out, {84{1'b1}});
        chk("rst_seg2", bus2.seg_out, {56{1'b1}});
        chk_status("rst", 4'b0000, a);
        reset_n = 1'b1;
        tick(9);
        chk("lat9_valid3", bus1.ch_valid, 4'b0000);
        chk_blank("lat9", 0);
        tick(1);
        chk_ch("lat10", 0, a[0]);
        chk_status("lat10", 4'b0001, a);

        // Hold raised mid-conversion of ch1 with new values presented.
        tick(4);
        hold = 1'b1;
        for (int c = 0; c < 4; c++) b[c] = $urandom_range(0, 255);
        val = b;
        drive();
        tick(10);
        chk_ch("hold_a", 1, a[1]);
        chk_status("hold_a", 4'b0011, a);
        tick(36);
        chk_ch("hold_b", 0, a[0]);
        chk_ch("hold_b", 1, a[1]);
        chk_blank("hold_b", 2);
        chk_blank("hold_b", 3);
        chk_status("hold_b", 4'b0011, a);
        hold = 1'b0;
        tick(9);
        chk_blank("resume9", 2);
        chk("resume9_valid", bus1.ch_valid, 4'b0011);
        tick(1);
        chk_ch("resume10", 2, b[2]);
        chk_ch("resume10", 0, a[0]);
        chk("resume10_valid", bus1.ch_valid, 4'b0111);

        // Reset asserted while ch3 is shifting.
        tick(4);
        reset_n = 1'b0;
        #1;
        chk("midrst_seg3", bus1.seg_out, {84{1'b1}});
        chk("midrst_seg2", bus2.seg_out, {56{1'b1}});
        chk("midrst_valid", bus1.ch_valid, 4'b0000);
        tick(2);
        reset_n = 1'b1;
        tick(9);
        chk("rerst9_valid", bus1.ch_valid, 4'b0000);
        tick(1);
        chk_ch("rerst10", 0, b[0]);
        chk("rerst10_valid", bus1.ch_valid, 4'b0001);

        // Fixed boundary rows followed by random rows, two full sweeps each.
        for (int r = 0; r < 12; r++) begin
            for (int c = 0; c < 4; c++)
                val[c] = (r < 4) ? fixed_rows[r][c] : int'($urandom_range(0, 255));
            drive();
            tick(80);
            for (int c = 0; c < 4; c++) chk_ch($sformatf("row%0d", r), c, val[c]);
            chk_status($sformatf("row%0d", r), 4'b1111, val);
        end

        // Walk ch0 through its full range with random traffic on the others.
        for (int v = 0; v < 256; v++) begin
            val[0] = v;
            for (int c = 1; c < 4; c++) val[c] = $urandom_range(0, 255);
            drive();
            tick(60);
            chk_ch("sweep", 0, v);
            chk("sweep_ovf2", bus2.ovf[0], (v >= 100));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
